// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types and default 640x480@60 raster constants for the VGA timing
//   generator and its axis counters.
//   Contents:
//     coord_t            11-bit pixel/line coordinate
//     H_ACTIVE..V_BP     default horizontal/vertical region sizes
//     COORD_LIMIT        largest total that fits an 11-bit counter
//     h_total/v_total    sum of the four regions of an axis
package vga_timing_pkg;

    typedef logic [10:0] coord_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int COORD_LIMIT = 2048;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter
//   One raster axis: a wrap counter plus combinational decode of the sync
//   window and the active window from the current count.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     advance      step the counter this edge
//     cnt          current count, 0..TOTAL-1
//     wrap         advance is high and cnt is at TOTAL-1 (counter returns to 0)
//     sync         POL inside [ACTIVE+FP, ACTIVE+FP+SYNC), else ~POL
//     active       cnt < ACTIVE
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter int   BP     = 48,
    parameter logic POL    = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   advance,
    output coord_t cnt,
    output logic   wrap,
    output logic   sync,
    output logic   active
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    logic at_end;

    // Compare in 32 bits so a bound of exactly 2048 cannot alias to 0.
    assign at_end = (32'(cnt) == TOTAL - 1);
    assign wrap   = advance && at_end;
    assign active = (32'(cnt) < ACTIVE);
    assign sync   = ((32'(cnt) >= SYNC_START) && (32'(cnt) < SYNC_END)) ? POL : ~POL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster-scan timing master for the VGA pipeline. Each clkEn-qualified edge
//   registers the outputs from the current (hCnt,vCnt) and then advances the
//   scan, so outputs trail the counters by one enabled clock.
//   Ports:
//     clk, reset     clock, asynchronous active-high reset
//     clkEn          pixel enable; the scan only moves when high
//     pixelX/pixelY  presented coordinate
//     hsync/vsync    sync outputs, active level HSYNC_POL/VSYNC_POL
//     blankN         1 inside the visible area
//     startOfFrame   one-clk pulse when (0,0) is presented
//     endOfFrame     one-clk pulse when the last pixel of the frame is presented
//   Build option VGA_SYNC_DELAY_EN: hsync/vsync/blankN get one extra enabled
//   register stage so they line up with registered object-block RGB.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP      = vga_timing_pkg::H_FP,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BP      = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP      = vga_timing_pkg::V_FP,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BP      = vga_timing_pkg::V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clkEn,
    output coord_t pixelX,
    output coord_t pixelY,
    output logic   hsync,
    output logic   vsync,
    output logic   blankN,
    output logic   startOfFrame,
    output logic   endOfFrame
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end

    coord_t h_cnt, v_cnt;
    logic   h_wrap, v_wrap;
    logic   h_sync, v_sync;
    logic   h_act, v_act;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
    ) u_h (
        .clk    (clk),
        .reset  (reset),
        .advance(clkEn),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_act)
    );

    // The line counter steps only when the pixel counter wraps, so its wrap
    // marks the last pixel of the frame.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
    ) u_v (
        .clk    (clk),
        .reset  (reset),
        .advance(h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .sync   (v_sync),
        .active (v_act)
    );

    logic hs_r, vs_r, blank_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelX       <= '0;
            pixelY       <= '0;
            hs_r         <= ~HSYNC_POL;
            vs_r         <= ~VSYNC_POL;
            blank_r      <= 1'b0;
            startOfFrame <= 1'b0;
            endOfFrame   <= 1'b0;
        end else begin
            // Pulses drop on any edge that does not re-assert them, which
            // keeps them one clk wide even with a divided pixel enable.
            startOfFrame <= 1'b0;
            endOfFrame   <= 1'b0;
            if (clkEn) begin
                pixelX       <= h_cnt;
                pixelY       <= v_cnt;
                hs_r         <= h_sync;
                vs_r         <= v_sync;
                blank_r      <= h_act && v_act;
                startOfFrame <= (h_cnt == '0) && (v_cnt == '0);
                endOfFrame   <= v_wrap;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d, vs_d, blank_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_d    <= ~HSYNC_POL;
            vs_d    <= ~VSYNC_POL;
            blank_d <= 1'b0;
        end else if (clkEn) begin
            hs_d    <= hs_r;
            vs_d    <= vs_r;
            blank_d <= blank_r;
        end
    end

    assign hsync  = hs_d;
    assign vsync  = vs_d;
    assign blankN = blank_d;
`else
    assign hsync  = hs_r;
    assign vsync  = vs_r;
    assign blankN = blank_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen on a reduced raster (30x15) so whole
//   frames fit in a short run. The stimulus process drives clkEn/reset at the
//   falling edge and pushes the expected post-edge outputs; the monitor pops
//   and compares one entry after every rising edge. The reference model maps
//   an enabled-edge index k straight to (k mod H_TOTAL, k div H_TOTAL) and
//   decodes regions arithmetically.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int   HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int   VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FT = HT * VT;
    localparam logic HP = 1'b0;
    localparam logic VP = 1'b1;

    logic   clk = 1'b0, reset = 1'b0, clkEn = 1'b0;
    coord_t pixelX, pixelY;
    logic   hsync, vsync, blankN, startOfFrame, endOfFrame;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clkEn       (clkEn),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .hsync       (hsync),
        .vsync       (vsync),
        .blankN      (blankN),
        .startOfFrame(startOfFrame),
        .endOfFrame  (endOfFrame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   x, y;
        logic hs, vs, bl, sof, eof;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;

    // Model state: index of the next enabled edge since reset, the currently
    // presented outputs, and the undelayed sync/blank of the last enabled edge.
    int   k = 0;
    exp_t cur;
    logic p_hs, p_vs, p_bl;

    function automatic exp_t reset_state();
        exp_t r;
        r.x = 0; r.y = 0; r.hs = ~HP; r.vs = ~VP; r.bl = 1'b0; r.sof = 1'b0; r.eof = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        k    = 0;
        cur  = reset_state();
        p_hs = ~HP; p_vs = ~VP; p_bl = 1'b0;
    endtask

    task automatic model_edge(input logic rst, input logic en);
        int   x, y;
        logic nhs, nvs, nbl;
        if (rst) begin
            model_reset();
        end else if (en) begin
            x   = k % HT;
            y   = (k / HT) % VT;
            nhs = (x >= HA + HF && x < HA + HF + HS) ? HP : ~HP;
            nvs = (y >= VA + VF && y < VA + VF + VS) ? VP : ~VP;
            nbl = (x < HA) && (y < VA);
            cur.x   = x;
            cur.y   = y;
            cur.sof = (k % FT == 0);
            cur.eof = (k % FT == FT - 1);
`ifdef VGA_SYNC_DELAY_EN
            cur.hs = p_hs; cur.vs = p_vs; cur.bl = p_bl;
`else
            cur.hs = nhs;  cur.vs = nvs;  cur.bl = nbl;
`endif
            p_hs = nhs; p_vs = nvs; p_bl = nbl;
            k++;
        end else begin
            cur.sof = 1'b0;
            cur.eof = 1'b0;
        end
        q.push_back(cur);
    endtask

    task automatic check(input string name, input exp_t e);
        tests++;
        if (int'(pixelX) != e.x || int'(pixelY) != e.y || hsync !== e.hs || vsync !== e.vs ||
            blankN !== e.bl || startOfFrame !== e.sof || endOfFrame !== e.eof) begin
            fails++;
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b bl=%b sof=%b eof=%b, expected x=%0d y=%0d hs=%b vs=%b bl=%b sof=%b eof=%b",
                     name, $time, pixelX, pixelY, hsync, vsync, blankN, startOfFrame, endOfFrame,
                     e.x, e.y, e.hs, e.vs, e.bl, e.sof, e.eof);
        end
    endtask

    task automatic step(input logic rst, input logic en);
        @(negedge clk);
        reset = rst;
        clkEn = en;
        model_edge(rst, en);
    endtask

    // Monitor: one expected entry per rising edge once stimulus is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("scan", e);
            end
        end
    end

    initial begin
        bit found;
        model_reset();
        #1 reset = 1'b1;
        #1 check("reset_async", reset_state());

        repeat (2) step(1'b1, 1'($urandom_range(0, 1)));

        // Continuous enable: two full frames plus a few pixels.
        repeat (2 * FT + 5) step(1'b0, 1'b1);

        // Divided pixel clock: enable every other edge.
        for (int i = 0; i < 2 * FT; i++) step(1'b0, (i % 2) == 0);

        // Random enable pattern.
        repeat (2 * FT) step(1'b0, 1'($urandom_range(0, 3) != 0));

        // Run to mid-frame, then assert reset between clock edges.
        found = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            step(1'b0, 1'b1);
            found = (cur.x == HT / 2) && (cur.y == VT / 2);
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL midframe_reach: model never reached (%0d,%0d)", HT / 2, VT / 2);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1 check("reset_midframe", reset_state());
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        // Release: the first enabled edge must present (0,0) with startOfFrame.
        step(1'b0, 1'b1);
        repeat (FT + 10) step(1'b0, 1'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
